// File: rtl/dp_pkg.sv
// Shared constants for the two-stage datapath core: op_code field encodings
// and flag bit positions.
package dp_pkg;

  localparam logic DP_ARITH = 1'b0;
  localparam logic DP_LOGIC = 1'b1;

  // Arithmetic-mode Y operand selects
  localparam logic [1:0] Y_ZERO = 2'b00;
  localparam logic [1:0] Y_B    = 2'b01;
  localparam logic [1:0] Y_NB   = 2'b10;
  localparam logic [1:0] Y_ONES = 2'b11;

  // Logic-mode function selects
  localparam logic [1:0] L_AND = 2'b00;
  localparam logic [1:0] L_OR  = 2'b01;
  localparam logic [1:0] L_XOR = 2'b10;
  localparam logic [1:0] L_NOT = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/dp_pipe_core_if.sv
// Issue/result bundle between the instruction sequencer (master) and the
// datapath core (slave).
interface dp_pipe_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              op_valid;
  logic [3:0]        op_code;
  logic [ADDR_W-1:0] A_addr;
  logic [ADDR_W-1:0] B_addr;
  logic [ADDR_W-1:0] D_addr;
  logic              nWE;
  logic              use_imm;
  logic [DATA_W-1:0] imm;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [3:0]        flags;

  modport master (
    output op_valid, op_code, A_addr, B_addr, D_addr, nWE, use_imm, imm,
    input  res_valid, res_data, flags
  );

  modport slave (
    input  op_valid, op_code, A_addr, B_addr, D_addr, nWE, use_imm, imm,
    output res_valid, res_data, flags
  );
endinterface

// File: rtl/dp_alu.sv
// Combinational arithmetic/logic unit: G = A + Y + C_in in arith mode,
// bitwise function of A/B in logic mode, plus {Z,N,C,V}.
module dp_alu
  import dp_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op_code,
  output logic [DATA_W-1:0] g,
  output logic [3:0]        flags
);

  logic              mode;
  logic [1:0]        sel;
  logic              c_in;
  logic [DATA_W-1:0] y;
  logic [DATA_W:0]   sum;

  assign mode = op_code[3];
  assign sel  = op_code[2:1];
  assign c_in = op_code[0];

  always_comb begin
    y     = '0;
    g     = '0;
    flags = '0;
    case (sel)
      Y_ZERO:  y = '0;
      Y_B:     y = b;
      Y_NB:    y = ~b;
      default: y = '1;
    endcase
    sum = {1'b0, a} + {1'b0, y} + {{DATA_W{1'b0}}, c_in};

    if (mode == DP_ARITH) begin
      g              = sum[DATA_W-1:0];
      flags[FLAG_C]  = sum[DATA_W];
      flags[FLAG_V]  = (a[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    end else begin
      // C_in is a don't-care here; C and V stay cleared
      case (sel)
        L_AND:   g = a & b;
        L_OR:    g = a | b;
        L_XOR:   g = a ^ b;
        default: g = ~a;
      endcase
    end
    flags[FLAG_Z] = (g == '0);
    flags[FLAG_N] = g[DATA_W-1];
  end

endmodule

// File: rtl/dp_pipe_core.sv
// Two-stage datapath: register file + operand capture (stage 1), ALU execute
// with registered result/flags and write-back (stage 2), with same-register bypass.
module dp_pipe_core
  import dp_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_CNT = 8,
  localparam int ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              nRST,
  dp_pipe_core_if.slave     bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] rf_q [REG_CNT];
  logic [DATA_W-1:0] rf_d [REG_CNT];

  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_op_q, s1_op_d;
  logic [ADDR_W-1:0] s1_dst_q, s1_dst_d;
  logic              s1_nwe_q, s1_nwe_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [3:0]        flags_q, flags_d;

  logic [DATA_W-1:0] alu_g;
  logic [3:0]        alu_flags;
  logic              byp_a, byp_b;

  dp_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (s1_a_q),
    .b       (s1_b_q),
    .op_code (s1_op_q),
    .g       (alu_g),
    .flags   (alu_flags)
  );

  always_comb begin
    // Only stage 1 can be in flight, so it is always the youngest producer
    byp_a = s1_valid_q && !s1_nwe_q && (s1_dst_q == bus.A_addr);
    byp_b = s1_valid_q && !s1_nwe_q && (s1_dst_q == bus.B_addr) && !bus.use_imm;

    s1_valid_d = bus.op_valid;
    s1_op_d    = s1_op_q;
    s1_dst_d   = s1_dst_q;
    s1_nwe_d   = s1_nwe_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (bus.op_valid) begin
      s1_op_d  = bus.op_code;
      s1_dst_d = bus.D_addr;
      s1_nwe_d = bus.nWE;
      s1_a_d   = byp_a ? alu_g : rf_q[bus.A_addr];
      if (bus.use_imm)
        s1_b_d = bus.imm;
      else
        s1_b_d = byp_b ? alu_g : rf_q[bus.B_addr];
    end

    res_valid_d = s1_valid_q;
    res_data_d  = res_data_q;
    flags_d     = flags_q;
    rf_d        = rf_q;
    if (s1_valid_q) begin
      res_data_d = alu_g;
      flags_d    = alu_flags;
      if (!s1_nwe_q)
        rf_d[s1_dst_q] = alu_g;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < REG_CNT; i++)
        rf_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_dst_q    <= '0;
      s1_nwe_q    <= 1'b1;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      flags_q     <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++)
        rf_q[i] <= rf_d[i];
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_dst_q    <= s1_dst_d;
      s1_nwe_q    <= s1_nwe_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.flags     = flags_q;
  assign dbg_data      = rf_q[dbg_addr];

endmodule
